// File: rtl/pipeline_sequencer_if.sv
// Bus between the pipeline sequencer and the rest of the CPU control path.
//   master : the sequencer. It takes in the memory word, the stall request and
//            the decoder results. It drives the instruction register, the
//            execute control bundle, datapath reset, the PC-update and
//            address-select controls, and the retired-instruction count.
//   slave  : the surrounding datapath (memory, decoder, register file, ALU).
interface pipeline_sequencer_if #(
  parameter int INSTR_W = 32,
  parameter int CTRL_W  = 64,
  parameter int CNT_W   = 32
);
  logic [INSTR_W-1:0] mem_instr;
  logic               stall;
  logic [CTRL_W-1:0]  dec_ctrl;
  logic               dec_is_branch;
  logic [INSTR_W-1:0] fd_instr;
  logic [CTRL_W-1:0]  ex_ctrl;
  logic               ex_valid;
  logic               control_reset;
  logic               pc_update;
  logic [1:0]         addr_sel;
  logic [CNT_W-1:0]   retired;

  modport master (
    input  mem_instr, stall, dec_ctrl, dec_is_branch,
    output fd_instr, ex_ctrl, ex_valid, control_reset, pc_update, addr_sel, retired
  );

  modport slave (
    output mem_instr, stall, dec_ctrl, dec_is_branch,
    input  fd_instr, ex_ctrl, ex_valid, control_reset, pc_update, addr_sel, retired
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Fetch/decode/execute sequencer for the CPU control path.
// It owns the instruction register (fd_*) and the decode-to-execute control
// register (de_*). It also drives PC-update and address-select for the
// address register.
//
// There are two operating modes:
//   PIPELINED=1 : fetch, decode and execute overlap, one instruction per cycle.
//                 A taken branch flushes the pipeline, which costs 2 bubbles.
//   PIPELINED=0 : the F, D and E phases run in sequence, one instruction
//                 every 3 cycles.
//
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : pipeline_sequencer_if.master. It carries mem_instr, stall,
//             dec_ctrl and dec_is_branch in, and fd_instr, ex_ctrl, ex_valid,
//             control_reset, pc_update, addr_sel and retired out.
module pipeline_sequencer #(
  parameter int                 INSTR_W      = 32,
  parameter int                 CTRL_W       = 64,
  parameter logic [INSTR_W-1:0] NOP_INSTR    = INSTR_W'(32'hE1A00000),
  parameter logic [CTRL_W-1:0]  CTRL_NOP     = '0,
  parameter int                 RESET_CYCLES = 2,
  parameter int                 PIPELINED    = 1,
  parameter int                 CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pipeline_sequencer_if.master bus
);

  localparam int              RC_W    = $clog2(RESET_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);

  localparam logic [2:0] ST_RESET = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_F     = 3'd2;
  localparam logic [2:0] ST_D     = 3'd3;
  localparam logic [2:0] ST_E     = 3'd4;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_PC  = 2'b01;
  localparam logic [1:0] SEL_INC = 2'b10;

  logic [2:0]         state_q,     state_d;
  logic [RC_W-1:0]    rst_cnt_q,   rst_cnt_d;
  logic               ctrl_rst_q,  ctrl_rst_d;
  logic [INSTR_W-1:0] fd_instr_q,  fd_instr_d;
  logic               fd_valid_q,  fd_valid_d;
  logic [CTRL_W-1:0]  de_ctrl_q,   de_ctrl_d;
  logic               de_valid_q,  de_valid_d;
  logic               de_branch_q, de_branch_d;
  logic [CNT_W-1:0]   retired_q,   retired_d;

  logic       ex_valid;
  logic       branch_taken;
  logic       pc_update;
  logic [1:0] addr_sel;

  // Execute outputs depend only on registers and stall. No path from
  // mem_instr reaches any output.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first.
    // Without the default, a path through the case that does not assign a
    // signal would infer a latch.
    ex_valid     = de_valid_q & ~bus.stall & ((state_q == ST_RUN) || (state_q == ST_E));
    branch_taken = ex_valid & de_branch_q;
    pc_update    = 1'b0;
    addr_sel     = SEL_PC;
    if (((state_q == ST_RUN) || (state_q == ST_E)) && !bus.stall) begin
      pc_update = 1'b1;
      addr_sel  = branch_taken ? SEL_ALU : SEL_INC;
    end
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    ctrl_rst_d  = ctrl_rst_q;
    fd_instr_d  = fd_instr_q;
    fd_valid_d  = fd_valid_q;
    de_ctrl_d   = de_ctrl_q;
    de_valid_d  = de_valid_q;
    de_branch_d = de_branch_q;
    retired_d   = retired_q;

    if (ex_valid) retired_d = retired_q + CNT_W'(1);

    case (state_q)
      ST_RESET: begin
        // Stall is ignored here. The exit edge also drops control_reset.
        if (rst_cnt_q == RC_LAST) begin
          state_d    = (PIPELINED != 0) ? ST_RUN : ST_F;
          ctrl_rst_d = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      ST_RUN: begin
        if (!bus.stall) begin
          if (branch_taken) begin
            // On a taken branch the flush wins. The word on mem_instr this
            // cycle is on the wrong path and is dropped.
            fd_instr_d  = NOP_INSTR;
            fd_valid_d  = 1'b0;
            de_valid_d  = 1'b0;
            de_branch_d = 1'b0;
          end else begin
            fd_instr_d  = bus.mem_instr;
            fd_valid_d  = 1'b1;
            de_ctrl_d   = bus.dec_ctrl;
            de_valid_d  = fd_valid_q;
            de_branch_d = bus.dec_is_branch & fd_valid_q;
          end
        end
      end
      ST_F: begin
        if (!bus.stall) begin
          fd_instr_d = bus.mem_instr;
          fd_valid_d = 1'b1;
          state_d    = ST_D;
        end
      end
      ST_D: begin
        if (!bus.stall) begin
          de_ctrl_d   = bus.dec_ctrl;
          de_valid_d  = fd_valid_q;
          de_branch_d = bus.dec_is_branch & fd_valid_q;
          state_d     = ST_E;
        end
      end
      ST_E: begin
        if (!bus.stall) begin
          de_valid_d  = 1'b0;
          de_branch_d = 1'b0;
          state_d     = ST_F;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RESET;
      rst_cnt_q   <= '0;
      ctrl_rst_q  <= 1'b1;
      fd_instr_q  <= NOP_INSTR;
      fd_valid_q  <= 1'b0;
      de_ctrl_q   <= CTRL_NOP;
      de_valid_q  <= 1'b0;
      de_branch_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      // NOTE: use non-blocking assignments here. Every flop then samples the
      // values from before the edge, whatever order the lines are written in.
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      ctrl_rst_q  <= ctrl_rst_d;
      fd_instr_q  <= fd_instr_d;
      fd_valid_q  <= fd_valid_d;
      de_ctrl_q   <= de_ctrl_d;
      de_valid_q  <= de_valid_d;
      de_branch_q <= de_branch_d;
      retired_q   <= retired_d;
    end
  end

  assign bus.fd_instr      = fd_instr_q;
  assign bus.ex_valid      = ex_valid;
  assign bus.ex_ctrl       = ex_valid ? de_ctrl_q : CTRL_NOP;
  assign bus.control_reset = ctrl_rst_q;
  assign bus.pc_update     = pc_update;
  assign bus.addr_sel      = addr_sel;
  assign bus.retired       = retired_q;

endmodule
